mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_arbiter                                                |
// | Description : Two-requester memory arbiter (IFU read port m0, LSU        |
// |               read/write port m1) with round-robin or fixed priority,    |
// |               registered outputs and a BUSY-phase timeout.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mem_arbiter #(
   parameter int ARB_MODE = 0,    // 0 = round-robin, 1 = m1 (LSU) always wins ties
   parameter int TIMEOUT  = 255   // BUSY cycles without mem_ready before error; 0 = off
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_valid,
   input  logic [31:0] m0_addr,
   output logic        m0_ready,
   input  logic        m1_valid,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [7:0]  m1_wmask,
   input  logic        m1_wen,
   output logic        m1_ready,
   output logic [31:0] rdata,
   output logic        err,
   output logic        mem_valid,
   output logic        mem_wen,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Timeout fires while the counter shows TIMEOUT-1, i.e. on the TIMEOUT-th BUSY cycle.
   localparam logic       c_to_en   = (TIMEOUT != 0);
   localparam logic [7:0] c_to_last = 8'(TIMEOUT - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_last_grant;      // 1 = m1 was served last
   logic        w_last_grant_nxt;
   logic        r_grant_id;        // 1 = m1 owns the current transaction
   logic        w_grant_id_nxt;
   logic [7:0]  r_cnt;
   logic [7:0]  w_cnt_nxt;
   logic        r_mem_valid, w_mem_valid_nxt;
   logic        r_mem_wen,   w_mem_wen_nxt;
   logic [31:0] r_mem_addr,  w_mem_addr_nxt;
   logic [31:0] r_mem_wdata, w_mem_wdata_nxt;
   logic [7:0]  r_mem_wmask, w_mem_wmask_nxt;
   logic [31:0] r_rdata,     w_rdata_nxt;
   logic        r_err,       w_err_nxt;
   logic        r_m0_ready,  w_m0_ready_nxt;
   logic        r_m1_ready,  w_m1_ready_nxt;
   logic        w_pick_m1;
   logic        w_timeout;

   // Winner selection: a lone requester wins; ties go by mode and last grant.
   assign w_pick_m1 = (m0_valid && m1_valid) ? ((ARB_MODE != 0) ? 1'b1 : ~r_last_grant)
                                             : m1_valid;

   assign w_timeout = c_to_en && (r_cnt == c_to_last);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      w_state_nxt      = r_state;
      w_last_grant_nxt = r_last_grant;
      w_grant_id_nxt   = r_grant_id;
      w_cnt_nxt        = r_cnt;
      w_mem_valid_nxt  = r_mem_valid;
      w_mem_wen_nxt    = r_mem_wen;
      w_mem_addr_nxt   = r_mem_addr;
      w_mem_wdata_nxt  = r_mem_wdata;
      w_mem_wmask_nxt  = r_mem_wmask;
      w_rdata_nxt      = r_rdata;
      w_err_nxt        = r_err;
      w_m0_ready_nxt   = 1'b0;
      w_m1_ready_nxt   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (m0_valid || m1_valid) begin
               w_state_nxt     = ST_BUSY;
               w_grant_id_nxt  = w_pick_m1;
               w_cnt_nxt       = 8'd0;
               w_mem_valid_nxt = 1'b1;
               if (w_pick_m1) begin
                  w_mem_addr_nxt  = m1_addr;
                  w_mem_wdata_nxt = m1_wdata;
                  w_mem_wmask_nxt = m1_wmask;
                  w_mem_wen_nxt   = m1_wen;
               end else begin
                  // The IFU port is read-only.
                  w_mem_addr_nxt  = m0_addr;
                  w_mem_wdata_nxt = 32'd0;
                  w_mem_wmask_nxt = 8'd0;
                  w_mem_wen_nxt   = 1'b0;
               end
            end
         end
         ST_BUSY: begin
            if (mem_ready || w_timeout) begin
               // mem_ready wins over a timeout firing in the same cycle.
               w_state_nxt     = ST_RESP;
               w_rdata_nxt     = mem_ready ? mem_rdata : 32'd0;
               w_err_nxt       = ~mem_ready;
               w_m0_ready_nxt  = ~r_grant_id;
               w_m1_ready_nxt  = r_grant_id;
               w_mem_valid_nxt = 1'b0;
               w_mem_wen_nxt   = 1'b0;
               w_mem_addr_nxt  = 32'd0;
               w_mem_wdata_nxt = 32'd0;
               w_mem_wmask_nxt = 8'd0;
            end else if (r_cnt != 8'hFF) begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         ST_RESP: begin
            w_state_nxt      = ST_IDLE;
            w_last_grant_nxt = r_grant_id;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_grant <= 1'b1;
         r_grant_id   <= 1'b0;
         r_cnt        <= 8'd0;
         r_mem_valid  <= 1'b0;
         r_mem_wen    <= 1'b0;
         r_mem_addr   <= 32'd0;
         r_mem_wdata  <= 32'd0;
         r_mem_wmask  <= 8'd0;
         r_rdata      <= 32'd0;
         r_err        <= 1'b0;
         r_m0_ready   <= 1'b0;
         r_m1_ready   <= 1'b0;
      end else begin
         r_last_grant <= w_last_grant_nxt;
         r_grant_id   <= w_grant_id_nxt;
         r_cnt        <= w_cnt_nxt;
         r_mem_valid  <= w_mem_valid_nxt;
         r_mem_wen    <= w_mem_wen_nxt;
         r_mem_addr   <= w_mem_addr_nxt;
         r_mem_wdata  <= w_mem_wdata_nxt;
         r_mem_wmask  <= w_mem_wmask_nxt;
         r_rdata      <= w_rdata_nxt;
         r_err        <= w_err_nxt;
         r_m0_ready   <= w_m0_ready_nxt;
         r_m1_ready   <= w_m1_ready_nxt;
      end
   end

   assign m0_ready  = r_m0_ready;
   assign m1_ready  = r_m1_ready;
   assign rdata     = r_rdata;
   assign err       = r_err;
   assign mem_valid = r_mem_valid;
   assign mem_wen   = r_mem_wen;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_wmask = r_mem_wmask;

endmodule
`default_nettype wire
